exception_ctrl: RTL
===================

Name: exception_ctrl

Overview:
- Sequencing controller for the LEGv8 exception path.
- Arbitrates NSRC level-sensitive peripheral interrupt lines, drives the decoder's ExtIRQ input, and traps invalid opcodes and illegal ERETs.
- Holds the architectural ELR/ESR registers and redirects fetch to the exception vector on entry and to ELR on ERET.
- Sits between the decoder/PC-select logic and the peripheral IRQ lines; non-nested, one handler at a time.

Parameters:
- N, 64, address/PC width.
- NSRC, 4, number of interrupt request lines; line 0 has highest priority.
- VECTOR, 64'h00000000000000D8, exception vector address.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- irq_req  in  NSRC  level-sensitive interrupt requests.
- irq_ack  out  NSRC  one-hot, one-cycle pulse when a source is dispatched.
- not_an_instr  in  1  decoder flag: current opcode invalid.
- eret  in  1  decoder flag: current instruction is ERET.
- pc_cur  in  N  PC of the instruction in the current cycle.
- ext_irq  out  1  to decoder ExtIRQ; suppresses the current instruction's side effects.
- redirect  out  1  one-cycle: fetch takes pc_redirect next cycle.
- pc_redirect  out  N  VECTOR on entry, elr on return.
- elr  out  N  exception link register.
- esr  out  4  exception status: 0001 IRQ, 0010 invalid opcode.
- irq_id  out  $clog2(NSRC)  index of last dispatched source.
- in_handler  out  1  high while state HANDLER.

Behaviour:
- Reset (synchronous, active-high):
  - state RUN, pend_q 0, elr 0, esr 0, irq_id 0.
  - All outputs 0.
  - Reset asserted mid-dispatch aborts it: no irq_ack, no redirect that cycle.
- States: RUN, IRQ, HANDLER. in_handler = (state == HANDLER).
- RUN:
  - If not_an_instr, or eret (ERET is illegal outside a handler):
    - elr <= pc_cur, esr <= 0010.
    - redirect = 1, pc_redirect = VECTOR.
    - Next state HANDLER.
  - Else if |irq_req: pend_q <= irq_req, next state IRQ. The current instruction completes normally.
  - Else stay in RUN.
  - If a synchronous exception and an IRQ occur in the same cycle, the synchronous exception wins. The IRQ stays pending (level) and is taken after return.
- IRQ (exactly one cycle):
  - ext_irq = 1, so the instruction at pc_cur is suppressed and re-executed on return.
  - elr <= pc_cur, esr <= 0001.
  - irq_id <= lowest set index of pend_q; irq_ack[irq_id] = 1 for this cycle only.
  - redirect = 1, pc_redirect = VECTOR. Next state HANDLER.
  - Dispatch uses the pend_q snapshot even if irq_req has already dropped.
  - not_an_instr is ignored in this cycle (ext_irq overrides the decoder).
- HANDLER:
  - irq_req is ignored (no nesting); lines stay pending.
  - eret: redirect = 1, pc_redirect = elr (current value), next state RUN.
  - not_an_instr (double fault): elr <= pc_cur, esr <= 0010, redirect = 1 to VECTOR, stay in HANDLER.
  - not_an_instr and eret together cannot occur (decoder is exclusive). If both are asserted, not_an_instr wins.
- Cycle after ERET:
  - State is RUN, so a still-asserted irq_req moves to IRQ on the next edge.
  - This gives a minimum of one instruction executed between handlers.
- Output timing:
  - redirect, pc_redirect, ext_irq and irq_ack are combinational from state and inputs.
  - elr, esr and irq_id are registered and update on the edge ending the triggering cycle.
  - ext_irq is never asserted outside IRQ.

Test Plan:
- Reset held 2 cycles with irq_req = 4'b1111 → all outputs 0 and state RUN during reset. On release, IRQ is entered on the 1st edge and irq_ack = 0001 in the 2nd cycle.
- RUN, pc_cur = 0x40, irq_req = 4'b0110 for one cycle only:
  - IRQ cycle with ext_irq = 1, pc_cur = 0x44: irq_ack = 0010, redirect to 0xD8.
  - Afterwards elr = 0x44, esr = 0001, irq_id = 1, in_handler = 1.
- In HANDLER, eret with elr = 0x44 → redirect = 1, pc_redirect = 0x44, in_handler drops next cycle. With irq_req = 0001 still high, the next IRQ dispatches id 0 after one RUN cycle.
- RUN, not_an_instr and irq_req = 1000 in the same cycle at pc_cur = 0x80:
  - Result: esr = 0010, elr = 0x80, redirect to 0xD8, no irq_ack.
  - After ERET, the IRQ dispatches with id 3.
- RUN, eret at pc_cur = 0x20 → invalid-opcode trap: esr = 0010, elr = 0x20, in_handler = 1.
- HANDLER, not_an_instr at pc_cur = 0xE0 → elr = 0xE0, esr = 0010, redirect to 0xD8, still in HANDLER. irq_req asserted throughout produces no irq_ack.

Source files
------------

// File: rtl/exception_ctrl.sv
// -----------------------------------------------------------------------------
// exception_ctrl
//   Sequencing controller for the LEGv8 exception path. Arbitrates the
//   level-sensitive peripheral IRQ lines, drives the decoder's ExtIRQ input,
//   traps invalid opcodes and ERETs outside a handler, holds ELR/ESR and
//   redirects fetch to the vector on entry and to ELR on return.
//   Non-nested: one handler at a time.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high
//   irq_req       level-sensitive interrupt requests, line 0 highest priority
//   irq_ack       one-hot pulse in the dispatch cycle (combinational)
//   not_an_instr  decoder: current opcode invalid
//   eret          decoder: current instruction is ERET
//   pc_cur        PC of the instruction in the current cycle
//   ext_irq       to decoder ExtIRQ, suppresses current instruction (comb.)
//   redirect      fetch takes pc_redirect next cycle (combinational)
//   pc_redirect   VECTOR on entry, elr on return (combinational)
//   elr           exception link register (registered)
//   esr           exception status: 0001 IRQ, 0010 invalid opcode (registered)
//   irq_id        index of last dispatched source (registered)
//   in_handler    high while in HANDLER
// -----------------------------------------------------------------------------
module exception_ctrl #(
   parameter int unsigned N      = 64,
   parameter int unsigned NSRC   = 4,
   parameter logic [N-1:0] VECTOR = 64'h00000000000000D8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NSRC-1:0]      irq_req,
   output logic [NSRC-1:0]      irq_ack,
   input  logic                 not_an_instr,
   input  logic                 eret,
   input  logic [N-1:0]         pc_cur,
   output logic                 ext_irq,
   output logic                 redirect,
   output logic [N-1:0]         pc_redirect,
   output logic [N-1:0]         elr,
   output logic [3:0]           esr,
   output logic [((NSRC > 1) ? $clog2(NSRC) : 1)-1:0] irq_id,
   output logic                 in_handler
);

   localparam int unsigned IW = (NSRC > 1) ? $clog2(NSRC) : 1;

   localparam logic [3:0] ESR_IRQ   = 4'b0001;
   localparam logic [3:0] ESR_UNDEF = 4'b0010;

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_IRQ     = 2'd1,
      S_HANDLER = 2'd2
   } state_t;

   state_t            r_state;
   logic [NSRC-1:0]   r_pend;
   logic [N-1:0]      r_elr;
   logic [3:0]        r_esr;
   logic [IW-1:0]     r_irq_id;

   logic [IW-1:0]     w_sel;
   logic              w_redirect;
   logic [N-1:0]      w_pc_redirect;
   logic              w_ext_irq;
   logic [NSRC-1:0]   w_irq_ack;

   // Lowest set index of the pending snapshot wins (scan high to low).
   always_comb begin
      w_sel = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (r_pend[i]) w_sel = IW'(i);
      end
   end

   // Combinational fetch/decoder controls; reset squashes any dispatch.
   always_comb begin
      w_redirect    = 1'b0;
      w_pc_redirect = '0;
      w_ext_irq     = 1'b0;
      w_irq_ack     = '0;
      if (!reset) begin
         case (r_state)
            S_RUN: begin
               if (not_an_instr || eret) begin
                  w_redirect    = 1'b1;
                  w_pc_redirect = VECTOR;
               end
            end
            S_IRQ: begin
               w_ext_irq     = 1'b1;
               w_irq_ack     = NSRC'(1) << w_sel;
               w_redirect    = 1'b1;
               w_pc_redirect = VECTOR;
            end
            S_HANDLER: begin
               if (not_an_instr) begin
                  w_redirect    = 1'b1;
                  w_pc_redirect = VECTOR;
               end else if (eret) begin
                  w_redirect    = 1'b1;
                  w_pc_redirect = r_elr;
               end
            end
            default: ;
         endcase
      end
   end

   // State machine and architectural registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_RUN;
         r_pend   <= '0;
         r_elr    <= '0;
         r_esr    <= '0;
         r_irq_id <= '0;
      end else begin
         case (r_state)
            S_RUN: begin
               // Synchronous exception beats a same-cycle IRQ; the IRQ level stays.
               if (not_an_instr || eret) begin
                  r_elr   <= pc_cur;
                  r_esr   <= ESR_UNDEF;
                  r_state <= S_HANDLER;
               end else if (|irq_req) begin
                  r_pend  <= irq_req;
                  r_state <= S_IRQ;
               end
            end
            S_IRQ: begin
               // Suppressed instruction at pc_cur is re-executed on return.
               r_elr    <= pc_cur;
               r_esr    <= ESR_IRQ;
               r_irq_id <= w_sel;
               r_state  <= S_HANDLER;
            end
            S_HANDLER: begin
               if (not_an_instr) begin
                  r_elr <= pc_cur;
                  r_esr <= ESR_UNDEF;
               end else if (eret) begin
                  r_state <= S_RUN;
               end
            end
            default: r_state <= S_RUN;
         endcase
      end
   end

   assign redirect    = w_redirect;
   assign pc_redirect = w_pc_redirect;
   assign ext_irq     = w_ext_irq;
   assign irq_ack     = w_irq_ack;
   assign elr         = r_elr;
   assign esr         = r_esr;
   assign irq_id      = r_irq_id;
   assign in_handler  = !reset && (r_state == S_HANDLER);

endmodule
